signed_accumulator: RTL and testbench

Signed fixed-point accumulator for the neuron datapath. It sums a frame of signed Q(DIN_INT).(DIN_WIDTH−DIN_INT) samples into a wider Q(DOUT_INT).(DOUT_WIDTH−DOUT_INT) register. On the frame's last sample it emits the total with a one-cycle valid pulse. It sits after the weight×input multiplier and before the activation stage.

---
 rtl/nn_fixed_pkg.sv | 27 ++
 rtl/signed_accumulator_if.sv | 14 +
 rtl/sig_align.sv | 26 ++
 rtl/signed_accumulator.sv | 88 ++++++++
 tb/tb_signed_accumulator.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/nn_fixed_pkg.sv
// rtl/nn_fixed_pkg.sv - fixed-point format helpers shared by the neuron datapath
package nn_fixed_pkg;

   function automatic int frac_bits(input int width, input int int_bits);
      return width - int_bits;
   endfunction

   // Distance between binary points; the direction comes from align_left().
   function automatic int align_shift(input int din_frac, input int dout_frac);
      return (dout_frac >= din_frac) ? (dout_frac - din_frac) : (din_frac - dout_frac);
   endfunction

   function automatic bit align_left(input int din_frac, input int dout_frac);
      return dout_frac >= din_frac;
   endfunction

   localparam int DEF_ALIGN_SHIFT = align_shift(frac_bits(16, 4), frac_bits(32, 14));

   function automatic logic [63:0] signed_max(input int width);
      return (64'd1 << (width - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] signed_min(input int width);
      return 64'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/signed_accumulator_if.sv
// rtl/signed_accumulator_if.sv - sample-in / frame-sum-out bundle of the accumulator
interface signed_accumulator_if #(
   parameter int DIN_WIDTH  = 16,
   parameter int DOUT_WIDTH = 32
);
   logic [DIN_WIDTH-1:0]  din;
   logic                  en;
   logic                  last;
   logic [DOUT_WIDTH-1:0] dout;
   logic                  dout_valid;

   modport master (output din, en, last, input dout, dout_valid);
   modport slave  (input din, en, last, output dout, dout_valid);
endinterface

// File: rtl/sig_align.sv
// rtl/sig_align.sv - combinational din-format to dout-format converter
module sig_align #(
   parameter int DIN_WIDTH  = 16,
   parameter int DOUT_WIDTH = 32,
   parameter int SHIFT      = 6,
   parameter bit SHIFT_LEFT = 1'b1
) (
   input  logic [DIN_WIDTH-1:0]  din_i,
   output logic [DOUT_WIDTH-1:0] aligned_o
);
   // Work in a width that holds both formats so a right shift never loses the sign.
   localparam int W = DIN_WIDTH + DOUT_WIDTH;

   logic signed [W-1:0] ext;
   logic signed [W-1:0] shifted;

   assign ext = {{DOUT_WIDTH{din_i[DIN_WIDTH-1]}}, din_i};

   if (SHIFT_LEFT) begin : g_left
      assign shifted = ext <<< SHIFT;
   end else begin : g_right
      assign shifted = ext >>> SHIFT;
   end

   assign aligned_o = shifted[DOUT_WIDTH-1:0];
endmodule

// File: rtl/signed_accumulator.sv
// rtl/signed_accumulator.sv - signed frame accumulator; SIG_ACC_SAT_EN selects saturating adds
module signed_accumulator
   import nn_fixed_pkg::*;
#(
   parameter int DIN_WIDTH  = 16,
   parameter int DIN_INT    = 4,
   parameter int DOUT_WIDTH = 32,
   parameter int DOUT_INT   = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   signed_accumulator_if.slave    bus
);
   localparam int DIN_FRAC  = frac_bits(DIN_WIDTH, DIN_INT);
   localparam int DOUT_FRAC = frac_bits(DOUT_WIDTH, DOUT_INT);
   localparam int SHIFT     = align_shift(DIN_FRAC, DOUT_FRAC);
   localparam bit LEFT      = align_left(DIN_FRAC, DOUT_FRAC);

   if (DOUT_INT < DIN_INT) begin : g_bad_format
      $error("signed_accumulator: DOUT_INT must be >= DIN_INT");
   end

   logic [DOUT_WIDTH-1:0] aligned;
   logic [DOUT_WIDTH-1:0] sum;
   logic [DOUT_WIDTH-1:0] acc_q, acc_d;
   logic [DOUT_WIDTH-1:0] dout_q, dout_d;
   logic                  valid_q, valid_d;

   sig_align #(
      .DIN_WIDTH  (DIN_WIDTH),
      .DOUT_WIDTH (DOUT_WIDTH),
      .SHIFT      (SHIFT),
      .SHIFT_LEFT (LEFT)
   ) u_align (
      .din_i     (bus.din),
      .aligned_o (aligned)
   );

`ifdef SIG_ACC_SAT_EN
   localparam logic [63:0] SAT_MAX_W = signed_max(DOUT_WIDTH);
   localparam logic [63:0] SAT_MIN_W = signed_min(DOUT_WIDTH);
   localparam logic [DOUT_WIDTH-1:0] SAT_MAX = SAT_MAX_W[DOUT_WIDTH-1:0];
   localparam logic [DOUT_WIDTH-1:0] SAT_MIN = SAT_MIN_W[DOUT_WIDTH-1:0];

   logic [DOUT_WIDTH:0] wide;

   // One guard bit: overflow shows up as the two top bits disagreeing.
   always_comb begin
      wide = {acc_q[DOUT_WIDTH-1], acc_q} + {aligned[DOUT_WIDTH-1], aligned};
      sum  = wide[DOUT_WIDTH-1:0];
      if (wide[DOUT_WIDTH] != wide[DOUT_WIDTH-1]) begin
         sum = wide[DOUT_WIDTH] ? SAT_MIN : SAT_MAX;
      end
   end
`else
   assign sum = acc_q + aligned;
`endif

   always_comb begin
      acc_d   = acc_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      if (bus.en) begin
         if (bus.last) begin
            dout_d  = sum;
            acc_d   = '0;
            valid_d = 1'b1;
         end else begin
            acc_d = sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = valid_q;
endmodule

// File: tb/tb_signed_accumulator.sv
// tb/tb_signed_accumulator.sv - self-checking bench for signed_accumulator
module tb_signed_accumulator;
   localparam int DIN_WIDTH  = 16;
   localparam int DIN_INT    = 4;
   localparam int DOUT_WIDTH = 32;
   localparam int DOUT_INT   = 14;
   localparam int SHIFT      = (DOUT_WIDTH - DOUT_INT) - (DIN_WIDTH - DIN_INT);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   signed_accumulator_if #(.DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)) bus ();

   signed_accumulator #(
      .DIN_WIDTH  (DIN_WIDTH),
      .DIN_INT    (DIN_INT),
      .DOUT_WIDTH (DOUT_WIDTH),
      .DOUT_INT   (DOUT_INT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   longint      m_acc   = 0;
   logic [31:0] m_dout  = '0;
   logic        m_valid = 1'b0;

   function automatic longint real_value(input logic [15:0] d);
      longint v;
      v = longint'($signed(d));
      return v * (longint'(1) << SHIFT);
   endfunction

   function automatic longint model_add(input longint a, input longint b);
      longint s;
      logic signed [31:0] t;
      s = a + b;
`ifdef SIG_ACC_SAT_EN
      if (s > 64'sd2147483647)  s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
      t = s[31:0];
      s = longint'(t);
`endif
      return s;
   endfunction

   task automatic send(input logic [15:0] d, input logic e, input logic l);
      longint s;
      bus.din  = d;
      bus.en   = e;
      bus.last = l;
      @(posedge clk);
      #1;
      m_valid = e && l;
      if (e) begin
         s = model_add(m_acc, real_value(d));
         if (l) begin
            m_dout = s[31:0];
            m_acc  = 0;
         end else begin
            m_acc = s;
         end
      end
      bus.en   = 1'b0;
      bus.last = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.din = '0; bus.en = 1'b0; bus.last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.dout !== 32'h0) begin
         failures++; $display("FAIL reset_dout got=%h exp=%h", bus.dout, 32'h0);
      end
      checks++;
      if (bus.dout_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid got=%b exp=0", bus.dout_valid);
      end
      rst = 1'b1;
      send(16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_directed();
      logic [15:0] mix [4] = '{16'h1000, 16'hF800, 16'hF800, 16'hFC00};
      for (int i = 0; i < 4; i++) send(16'h1000, 1'b1, i == 3);
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== 32'h00100000) begin
         failures++; $display("FAIL four_ones got=%h/%b exp=00100000/1", bus.dout, bus.dout_valid);
      end
      send(16'h0000, 1'b0, 1'b0);
      checks++;
      if (bus.dout_valid !== 1'b0 || bus.dout !== 32'h00100000) begin
         failures++; $display("FAIL pulse_width got=%h/%b exp=00100000/0", bus.dout, bus.dout_valid);
      end
      for (int i = 0; i < 4; i++) send(mix[i], 1'b1, i == 3);
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== 32'hFFFF0000) begin
         failures++; $display("FAIL mixed_sign got=%h/%b exp=ffff0000/1", bus.dout, bus.dout_valid);
      end
   endtask

   task automatic test_gaps();
      for (int i = 0; i < 3; i++) begin
         send(16'h1000, 1'b1, i == 2);
         if (i < 2) begin
            for (int g = 0; g < 2; g++) begin
               send(16'h7777, 1'b0, 1'b1);
               checks++;
               if (bus.dout_valid !== 1'b0) begin
                  failures++; $display("FAIL gap_valid got=%b exp=0", bus.dout_valid);
               end
            end
         end
      end
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== 32'h000C0000) begin
         failures++; $display("FAIL gap_sum got=%h/%b exp=000c0000/1", bus.dout, bus.dout_valid);
      end
   endtask

   task automatic test_back_to_back();
      send(16'h2000, 1'b1, 1'b1);
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== 32'h00080000) begin
         failures++; $display("FAIL b2b_first got=%h/%b exp=00080000/1", bus.dout, bus.dout_valid);
      end
      send(16'h1000, 1'b1, 1'b1);
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== 32'h00040000) begin
         failures++; $display("FAIL b2b_second got=%h/%b exp=00040000/1", bus.dout, bus.dout_valid);
      end
   endtask

   task automatic test_reset_midframe();
      send(16'h1000, 1'b1, 1'b0);
      send(16'h1000, 1'b1, 1'b0);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.dout !== 32'h0 || bus.dout_valid !== 1'b0) begin
         failures++; $display("FAIL async_reset got=%h/%b exp=00000000/0", bus.dout, bus.dout_valid);
      end
      m_acc = 0; m_dout = '0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         send(16'h1000, 1'b1, i == 1);
         if (i == 0) begin
            checks++;
            if (bus.dout_valid !== 1'b0) begin
               failures++; $display("FAIL aborted_pulse got=%b exp=0", bus.dout_valid);
            end
         end
      end
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== 32'h00080000) begin
         failures++; $display("FAIL after_reset got=%h/%b exp=00080000/1", bus.dout, bus.dout_valid);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 1100; i++) send(16'h7FFF, 1'b1, i == 1099);
      checks++;
`ifdef SIG_ACC_SAT_EN
      if (bus.dout !== 32'h7FFFFFFF) begin
         failures++; $display("FAIL overflow_sat got=%h exp=7fffffff", bus.dout);
      end
`else
      if (bus.dout !== 32'h897EED00) begin
         failures++; $display("FAIL overflow_wrap got=%h exp=897eed00", bus.dout);
      end
`endif
      for (int i = 0; i < 1100; i++) send(16'h8000, 1'b1, i == 1099);
      checks++;
      if (bus.dout !== m_dout) begin
         failures++; $display("FAIL overflow_neg got=%h exp=%h", bus.dout, m_dout);
      end
   endtask

   task automatic test_random();
      int len;
      for (int f = 0; f < 150; f++) begin
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) send(16'($urandom), 1'b0, 1'($urandom));
            else begin
               send(16'($urandom), 1'b1, i == len - 1);
               i = i;
            end
            checks++;
            if (bus.dout_valid !== m_valid || bus.dout !== m_dout) begin
               failures++;
               $display("FAIL random f=%0d got=%h/%b exp=%h/%b", f, bus.dout, bus.dout_valid, m_dout, m_valid);
            end
         end
         send(16'h0, 1'b1, 1'b1);
         checks++;
         if (bus.dout_valid !== 1'b1 || bus.dout !== m_dout) begin
            failures++;
            $display("FAIL random_close f=%0d got=%h/%b exp=%h/1", f, bus.dout, bus.dout_valid, m_dout);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_gaps();
      test_back_to_back();
      test_reset_midframe();
      test_overflow();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
